// File: rtl/regfile_mp.sv
// Multi-port register file: N_READ combinational read ports, two synchronous write ports,
// optional same-cycle write-to-read bypass, and a per-register pending-write scoreboard.
// Latency: reads 0 cycles, writes visible the next cycle (same cycle when bypassed); no backpressure.
// Ports:
//   Clock, nReset          rising-edge clock, async active-low reset
//   WrEn0/WrAddr0/WrData0  write port 0 (WB pipe)
//   WrEn1/WrAddr1/WrData1  write port 1 (load/mul pipe), wins over port 0 on the same address
//   RdAddr/RdData/RdBusy   packed read ports, lane i at [i*W +: W]; RdBusy = pending write outstanding
//   SbSet/SbAddr           mark a destination pending at issue
//   Flush                  clear every pending bit
//   RegAddr/RegData        debug read of the stored value (never bypassed)
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int N_READ   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       Clock,
  input  logic                       nReset,
  input  logic                       WrEn0,
  input  logic [ADDR_W-1:0]          WrAddr0,
  input  logic [DATA_W-1:0]          WrData0,
  input  logic                       WrEn1,
  input  logic [ADDR_W-1:0]          WrAddr1,
  input  logic [DATA_W-1:0]          WrData1,
  input  logic [N_READ*ADDR_W-1:0]   RdAddr,
  output logic [N_READ*DATA_W-1:0]   RdData,
  output logic [N_READ-1:0]          RdBusy,
  input  logic                       SbSet,
  input  logic [ADDR_W-1:0]          SbAddr,
  input  logic                       Flush,
  input  logic [ADDR_W-1:0]          RegAddr,
  output logic [DATA_W-1:0]          RegData
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pending;
  logic [DEPTH-1:0]  pend_nxt;

  // Hard-wired zero register: address 0 when ZERO_REG is enabled.
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Port 1 is written after port 0 so it wins on an address collision.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
    end else begin
      if (WrEn0 && !is_zero(WrAddr0)) regs[WrAddr0] <= WrData0;
      if (WrEn1 && !is_zero(WrAddr1)) regs[WrAddr1] <= WrData1;
    end
  end

  // Scoreboard update, lowest priority first: write completions clear, issue sets
  // (a new producer outlives a write landing in the same cycle), flush clears everything.
  always_comb begin
    pend_nxt = pending;
    if (WrEn0) pend_nxt[WrAddr0] = 1'b0;
    if (WrEn1) pend_nxt[WrAddr1] = 1'b0;
    if (SbSet && !is_zero(SbAddr)) pend_nxt[SbAddr] = 1'b1;
    if (Flush) pend_nxt = '0;
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) pending <= '0;
    else         pending <= pend_nxt;
  end

  logic [ADDR_W-1:0] ra;
  logic [DATA_W-1:0] rd;
  logic              rb;

  // Read lanes: stored value and pending bit, overridden by a same-cycle write when
  // bypass is enabled (port 1 first), and forced to zero for the zero register.
  always_comb begin
    RdData = '0;
    RdBusy = '0;
    ra     = '0;
    rd     = '0;
    rb     = 1'b0;
    for (int i = 0; i < N_READ; i++) begin
      ra = RdAddr[i*ADDR_W +: ADDR_W];
      rd = regs[ra];
      rb = pending[ra];
      if (BYPASS != 0) begin
        if (WrEn1 && (WrAddr1 == ra)) begin
          rd = WrData1;
          rb = 1'b0;
        end else if (WrEn0 && (WrAddr0 == ra)) begin
          rd = WrData0;
          rb = 1'b0;
        end
      end
      if (is_zero(ra)) begin
        rd = '0;
        rb = 1'b0;
      end
      RdData[i*DATA_W +: DATA_W] = rd;
      RdBusy[i]                  = rb;
    end
  end

  // Register 0 is never written when it is the zero register, so the stored value is already 0.
  assign RegData = regs[RegAddr];

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        Clock;
  logic        nReset;
  logic        WrEn0;
  logic [4:0]  WrAddr0;
  logic [31:0] WrData0;
  logic        WrEn1;
  logic [4:0]  WrAddr1;
  logic [31:0] WrData1;
  logic [9:0]  RdAddr;
  logic [63:0] RdData;
  logic [1:0]  RdBusy;
  logic        SbSet;
  logic [4:0]  SbAddr;
  logic        Flush;
  logic [4:0]  RegAddr;
  logic [31:0] RegData;

  int checks = 0;
  int errors = 0;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .N_READ(2), .ZERO_REG(1), .BYPASS(1)
  ) dut (
    .Clock(Clock), .nReset(nReset),
    .WrEn0(WrEn0), .WrAddr0(WrAddr0), .WrData0(WrData0),
    .WrEn1(WrEn1), .WrAddr1(WrAddr1), .WrData1(WrData1),
    .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
    .SbSet(SbSet), .SbAddr(SbAddr), .Flush(Flush),
    .RegAddr(RegAddr), .RegData(RegData)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic        w0e;
    logic [4:0]  w0a;
    logic [31:0] w0d;
    logic        w1e;
    logic [4:0]  w1a;
    logic [31:0] w1d;
    logic        sb;
    logic [4:0]  sba;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [4:0]  ra;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] er;
  } vec_t;

  typedef struct {
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [31:0] er;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  // Reference state for the random phase.
  logic [31:0] m_reg  [32];
  logic        m_pend [32];

  function automatic vec_t mk(
    input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
    input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
    input logic sb, input logic [4:0] sba, input logic fl,
    input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] ra,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb, input logic [31:0] er);
    vec_t v;
    v.w0e = w0e; v.w0a = w0a; v.w0d = w0d;
    v.w1e = w1e; v.w1a = w1a; v.w1d = w1d;
    v.sb = sb; v.sba = sba; v.fl = fl;
    v.r0 = r0; v.r1 = r1; v.ra = ra;
    v.e0 = e0; v.e1 = e1; v.eb = eb; v.er = er;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    WrEn0 = 0; WrAddr0 = 0; WrData0 = 0;
    WrEn1 = 0; WrAddr1 = 0; WrData1 = 0;
    SbSet = 0; SbAddr = 0; Flush = 0;
    RdAddr = 0; RegAddr = 0;
  endtask

  // Drive one cycle of stimulus just after the falling edge, push its expectation,
  // then compare the combinational outputs well before the next rising edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge Clock);
    #1;
    WrEn0 = v.w0e; WrAddr0 = v.w0a; WrData0 = v.w0d;
    WrEn1 = v.w1e; WrAddr1 = v.w1a; WrData1 = v.w1d;
    SbSet = v.sb;  SbAddr = v.sba;  Flush = v.fl;
    RdAddr = {v.r1, v.r0}; RegAddr = v.ra;
    e.e0 = v.e0; e.e1 = v.e1; e.eb = v.eb; e.er = v.er;
    sbq.push_back(e);
    #2;
    if (sbq.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sbq.pop_front();
      cmp({tag, " rd0"},  RdData[31:0],  e.e0);
      cmp({tag, " rd1"},  RdData[63:32], e.e1);
      cmp({tag, " busy"}, {30'd0, RdBusy}, {30'd0, e.eb});
      cmp({tag, " reg"},  RegData,       e.er);
    end
  endtask

  // Expected outputs for a stimulus vector, from the reference state before the edge.
  task automatic model_expect(inout vec_t v);
    logic [4:0]  a;
    logic [31:0] d;
    logic        b;
    for (int p = 0; p < 2; p++) begin
      a = (p == 0) ? v.r0 : v.r1;
      d = m_reg[a];
      b = m_pend[a];
      if (v.w1e && v.w1a == a)      begin d = v.w1d; b = 1'b0; end
      else if (v.w0e && v.w0a == a) begin d = v.w0d; b = 1'b0; end
      if (a == 5'd0)                begin d = '0;    b = 1'b0; end
      if (p == 0) v.e0 = d; else v.e1 = d;
      v.eb[p] = b;
    end
    v.er = m_reg[v.ra];
  endtask

  task automatic model_update(input vec_t v);
    if (v.w0e && v.w0a != 5'd0) m_reg[v.w0a] = v.w0d;
    if (v.w1e && v.w1a != 5'd0) m_reg[v.w1a] = v.w1d;
    if (v.fl) begin
      for (int k = 0; k < 32; k++) m_pend[k] = 1'b0;
    end else begin
      if (v.w0e) m_pend[v.w0a] = 1'b0;
      if (v.w1e) m_pend[v.w1a] = 1'b0;
      if (v.sb && v.sba != 5'd0) m_pend[v.sba] = 1'b1;
    end
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    nReset = 1'b0;

    //            w0e w0a   w0d            w1e w1a   w1d           sb sba   fl r0    r1    ra     e0             e1             eb     er
    // single write, bypass on both lanes, then stored
    vecs.push_back(mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd5,  5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd5,  5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        2'b00, 32'hDEADBEEF));
    // both ports to reg 7: port 1 wins
    vecs.push_back(mk(1, 5'd7,  32'h1,        1, 5'd7,  32'h2,        0, 5'd0, 0, 5'd7,  5'd7,  5'd7,  32'h2,        32'h2,        2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd7,  5'd0,  5'd7,  32'h2,        32'h0,        2'b00, 32'h2));
    // zero register ignores writes and scoreboard
    vecs.push_back(mk(1, 5'd0,  32'hFFFFFFFF, 1, 5'd0,  32'hFFFFFFFF, 1, 5'd0, 0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0));
    // scoreboard on reg 9
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd9, 0, 5'd9,  5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd9,  5'd9,  5'd0,  32'h0,        32'h0,        2'b11, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        1, 5'd9,  32'h99,       0, 5'd0, 0, 5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd9,  5'd9,  5'd9,  32'h99,       32'h99,       2'b00, 32'h99));
    vecs.push_back(mk(1, 5'd9,  32'hAA,       0, 5'd0,  32'h0,        1, 5'd9, 0, 5'd9,  5'd0,  5'd9,  32'hAA,       32'h0,        2'b00, 32'h99));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd9,  5'd0,  5'd9,  32'hAA,       32'h0,        2'b01, 32'hAA));
    vecs.push_back(mk(1, 5'd9,  32'hBB,       0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd9,  5'd9,  5'd9,  32'hBB,       32'hBB,       2'b00, 32'hAA));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd9,  5'd0,  5'd9,  32'hBB,       32'h0,        2'b00, 32'hBB));
    // pend 3 and 4, flush with a same-cycle set of 6
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd3, 0, 5'd3,  5'd4,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd4, 0, 5'd3,  5'd4,  5'd0,  32'h0,        32'h0,        2'b01, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd6, 1, 5'd3,  5'd4,  5'd0,  32'h0,        32'h0,        2'b11, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd4,  5'd6,  5'd0,  32'h0,        32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd3,  5'd9,  5'd0,  32'h0,        32'hBB,       2'b00, 32'h0));
    // independent writes on both ports, crossed reads
    vecs.push_back(mk(1, 5'd12, 32'h12,       1, 5'd13, 32'h13,       0, 5'd0, 0, 5'd13, 5'd12, 5'd12, 32'h13,       32'h12,       2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd12, 5'd13, 5'd13, 32'h12,       32'h13,       2'b00, 32'h13));
    // a write to another address does not mask a pending read
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        1, 5'd20, 0, 5'd20, 5'd0, 5'd0,  32'h0,        32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(1, 5'd21, 32'h21,       0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd20, 5'd21, 5'd0,  32'h0,        32'h21,       2'b01, 32'h0));
    vecs.push_back(mk(1, 5'd20, 32'h20,       0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd20, 5'd0,  5'd0,  32'h20,       32'h0,        2'b00, 32'h0));
    vecs.push_back(mk(0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 5'd20, 5'd0,  5'd20, 32'h20,       32'h0,        2'b00, 32'h20));

    // Reset state on every address and both lanes.
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    #2 nReset = 1'b1;
    for (int a = 0; a < 32; a++) begin
      RdAddr  = {5'(31 - a), 5'(a)};
      RegAddr = 5'(a);
      #0.1;
      cmp($sformatf("reset rd0 a%0d", a), RdData[31:0], 32'h0);
      cmp($sformatf("reset rd1 a%0d", a), RdData[63:32], 32'h0);
      cmp($sformatf("reset busy a%0d", a), {30'd0, RdBusy}, 32'h0);
      cmp($sformatf("reset reg a%0d", a), RegData, 32'h0);
    end

    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset pulse in the middle of operation.
    @(negedge Clock);
    #1;
    idle_inputs();
    SbSet = 1; SbAddr = 5'd30;
    @(negedge Clock);
    #1;
    idle_inputs();
    RdAddr = {5'd5, 5'd30};
    #1;
    cmp("pre-reset busy", {30'd0, RdBusy}, 32'h1);
    cmp("pre-reset rd1", RdData[63:32], 32'hDEADBEEF);
    WrEn0 = 1; WrAddr0 = 5'd8; WrData0 = 32'h55;
    RegAddr = 5'd8;
    nReset = 1'b0;
    #1;
    cmp("in-reset busy", {30'd0, RdBusy}, 32'h0);
    cmp("in-reset rd1", RdData[63:32], 32'h0);
    cmp("in-reset reg8", RegData, 32'h0);
    @(negedge Clock);
    @(negedge Clock);
    #2 nReset = 1'b1;
    #1;
    cmp("post-release reg8", RegData, 32'h0);
    @(negedge Clock);
    #1;
    WrEn0 = 0;
    cmp("first write after reset", RegData, 32'h55);
    RegAddr = 5'd5;
    #1;
    cmp("reg5 cleared by reset", RegData, 32'h0);
    RegAddr = 5'd9;
    #1;
    cmp("reg9 cleared by reset", RegData, 32'h0);

    // Randomised traffic against the reference state.
    for (int k = 0; k < 32; k++) begin
      m_reg[k]  = 32'h0;
      m_pend[k] = 1'b0;
    end
    m_reg[8] = 32'h55;
    for (int n = 0; n < 300; n++) begin
      v.w0e = ($urandom_range(0, 2) == 0);
      v.w0a = 5'($urandom_range(0, 7));
      v.w0d = $urandom;
      v.w1e = ($urandom_range(0, 2) == 0);
      v.w1a = 5'($urandom_range(0, 7));
      v.w1d = $urandom;
      v.sb  = ($urandom_range(0, 2) == 0);
      v.sba = 5'($urandom_range(0, 7));
      v.fl  = ($urandom_range(0, 9) == 0);
      v.r0  = 5'($urandom_range(0, 7));
      v.r1  = 5'($urandom_range(0, 7));
      v.ra  = 5'($urandom_range(0, 8));
      v.e0 = '0; v.e1 = '0; v.eb = '0; v.er = '0;
      model_expect(v);
      apply(v, $sformatf("rand%0d", n));
      model_update(v);
    end

    @(negedge Clock);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
